// File: rtl/free_list.sv
// Physical-register free list for the rename stage: hands out and reclaims
// tags through a circular buffer and keeps head checkpoints aligned with the RAT.
module free_list #(
  parameter int P_ADDR_WIDTH = 7,
  parameter int L_ADDR_WIDTH = 5,
  parameter int C_NUM        = 4,
  parameter int INSTR_COUNT  = 2
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [INSTR_COUNT-1:0]                    pop_req,
  output logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]  pop_data,
  output logic                                      pop_ready,
  input  logic [INSTR_COUNT-1:0]                    push_en,
  input  logic [INSTR_COUNT-1:0][P_ADDR_WIDTH-1:0]  push_data,
  input  logic                                      take_checkpoint,
  input  logic [INSTR_COUNT-1:0]                    instr_to_checkpoint,
  input  logic                                      restore_checkpoint,
  input  logic [$clog2(C_NUM)-1:0]                  new_checkpoint,
  output logic [P_ADDR_WIDTH:0]                     free_count,
  output logic [$clog2(C_NUM)-1:0]                  ckpt_head
);

  localparam int DEPTH     = 2 ** P_ADDR_WIDTH;
  localparam int L_REGS    = 2 ** L_ADDR_WIDTH;
  localparam int FREE_INIT = DEPTH - L_REGS;
  localparam int CW        = $clog2(C_NUM);

  typedef logic [P_ADDR_WIDTH-1:0] ptr_t;
  localparam ptr_t                  PTR_ONE   = ptr_t'(1);
  localparam logic [CW-1:0]         CK_ONE    = CW'(1);
  localparam logic [P_ADDR_WIDTH:0] COUNT_MAX = (P_ADDR_WIDTH+1)'(FREE_INIT);

  ptr_t                  buf_q [DEPTH];
  ptr_t                  ckpt_q [C_NUM];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  logic [P_ADDR_WIDTH:0] count_q, count_d;
  logic [CW-1:0]         ckpt_head_q, ckpt_head_d;

  ptr_t                  popCnt;
  ptr_t                  pushCnt;
  ptr_t                  ckptCnt;
  ptr_t                  pushAddr [INSTR_COUNT];
  logic [INSTR_COUNT-1:0] ckptMask;
  logic                  popGrant;
  logic                  takeEn;

  // Requesting lanes are compacted onto consecutive buffer slots from head.
  always_comb begin
    popCnt = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      pop_data[i] = buf_q[head_q + popCnt];
      if (pop_req[i]) popCnt = popCnt + PTR_ONE;
    end
  end

  always_comb begin
    pushCnt = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      pushAddr[i] = tail_q + pushCnt;
      if (push_en[i]) pushCnt = pushCnt + PTR_ONE;
    end
  end

  // The checkpointed head includes pops of lanes older than the branch.
  always_comb begin
    ckptMask = pop_req & (instr_to_checkpoint - INSTR_COUNT'(1));
    ckptCnt  = '0;
    for (int i = 0; i < INSTR_COUNT; i++) begin
      if (ckptMask[i]) ckptCnt = ckptCnt + PTR_ONE;
    end
  end

  always_comb begin
    pop_ready = (count_q >= {1'b0, popCnt});
    popGrant  = pop_ready & ~restore_checkpoint;
    takeEn    = take_checkpoint & pop_ready & ~restore_checkpoint;

    head_d = head_q;
    if (restore_checkpoint) head_d = ckpt_q[new_checkpoint];
    else if (popGrant)      head_d = head_q + popCnt;

    tail_d  = tail_q + pushCnt;
    count_d = {1'b0, ptr_t'(tail_d - head_d)};

    ckpt_head_d = ckpt_head_q;
    if (restore_checkpoint) ckpt_head_d = new_checkpoint + CK_ONE;
    else if (takeEn)        ckpt_head_d = ckpt_head_q + CK_ONE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q      <= '0;
      tail_q      <= ptr_t'(FREE_INIT);
      count_q     <= COUNT_MAX;
      ckpt_head_q <= '0;
      for (int j = 0; j < DEPTH; j++) begin
        buf_q[j] <= (j < FREE_INIT) ? ptr_t'(L_REGS + j) : '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      ckpt_head_q <= ckpt_head_d;
      for (int i = 0; i < INSTR_COUNT; i++) begin
        if (push_en[i]) buf_q[pushAddr[i]] <= push_data[i];
      end
    end
  end

  // Checkpoint storage carries no reset; slots are always written before use.
  always_ff @(posedge clk) begin
    if (takeEn) ckpt_q[ckpt_head_q] <= head_q + ckptCnt;
  end

  assign free_count = count_q;
  assign ckpt_head  = ckpt_head_q;

  pushOverflow: assert property (@(posedge clk) disable iff (!rst_n) count_d <= COUNT_MAX);

endmodule

// File: tb/tb_free_list.sv
// Directed self-checking bench for free_list: pops, compaction, backpressure,
// checkpoint take/restore, push during restore and sustained wrap-around traffic.
module tb_free_list;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [1:0]      pop_req;
  logic [1:0][6:0] pop_data;
  logic            pop_ready;
  logic [1:0]      push_en;
  logic [1:0][6:0] push_data;
  logic            take_checkpoint;
  logic [1:0]      instr_to_checkpoint;
  logic            restore_checkpoint;
  logic [1:0]      new_checkpoint;
  logic [7:0]      free_count;
  logic [1:0]      ckpt_head;

  int errorCount = 0;
  int checkCount = 0;

  free_list dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .pop_req             (pop_req),
    .pop_data            (pop_data),
    .pop_ready           (pop_ready),
    .push_en             (push_en),
    .push_data           (push_data),
    .take_checkpoint     (take_checkpoint),
    .instr_to_checkpoint (instr_to_checkpoint),
    .restore_checkpoint  (restore_checkpoint),
    .new_checkpoint      (new_checkpoint),
    .free_count          (free_count),
    .ckpt_head           (ckpt_head)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] req, input logic [1:0] pEn,
                               input logic [6:0] d0, input logic [6:0] d1,
                               input logic take, input logic [1:0] itc,
                               input logic restore, input logic [1:0] newCk);
    pop_req             = req;
    push_en             = pEn;
    push_data[0]        = d0;
    push_data[1]        = d1;
    take_checkpoint     = take;
    instr_to_checkpoint = itc;
    restore_checkpoint  = restore;
    new_checkpoint      = newCk;
    #2;
  endtask

  task automatic popOnly(input logic [1:0] req);
    applyStimulus(req, 2'b00, 7'd0, 7'd0, 1'b0, 2'b00, 1'b0, 2'd0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    popOnly(2'b00);
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  logic [6:0] q[$];
  logic [6:0] e0, e1;

  initial begin
    rst_n = 1'b0;

    // Reset state and a full 2-wide pop
    doReset();
    checkOutput("reset_count", 32'(free_count), 32'd96);
    checkOutput("reset_ckpt_head", 32'(ckpt_head), 32'd0);
    checkOutput("reset_ready_idle", 32'(pop_ready), 32'd1);
    popOnly(2'b11);
    checkOutput("pop11_ready", 32'(pop_ready), 32'd1);
    checkOutput("pop11_lane0", 32'(pop_data[0]), 32'd32);
    checkOutput("pop11_lane1", 32'(pop_data[1]), 32'd33);
    tick();
    checkOutput("pop11_count", 32'(free_count), 32'd94);
    popOnly(2'b01);
    checkOutput("pop11_next", 32'(pop_data[0]), 32'd34);
    tick();

    // Compaction onto the upper lane
    doReset();
    popOnly(2'b10);
    checkOutput("compact_lane1", 32'(pop_data[1]), 32'd32);
    tick();
    popOnly(2'b01);
    checkOutput("compact_next_lane0", 32'(pop_data[0]), 32'd33);
    tick();
    popOnly(2'b00);
    checkOutput("compact_count", 32'(free_count), 32'd94);

    // Drain to one free tag, then all-or-nothing refusal
    doReset();
    for (int n = 0; n < 47; n++) begin
      popOnly(2'b11);
      tick();
    end
    popOnly(2'b01);
    checkOutput("drain_tag94", 32'(pop_data[0]), 32'd126);
    tick();
    checkOutput("drain_count1", 32'(free_count), 32'd1);
    popOnly(2'b11);
    checkOutput("short_ready", 32'(pop_ready), 32'd0);
    tick();
    checkOutput("short_count_held", 32'(free_count), 32'd1);
    popOnly(2'b01);
    checkOutput("last_ready", 32'(pop_ready), 32'd1);
    checkOutput("last_tag", 32'(pop_data[0]), 32'd127);
    tick();
    checkOutput("empty_count", 32'(free_count), 32'd0);
    popOnly(2'b00);
    checkOutput("empty_idle_ready", 32'(pop_ready), 32'd1);
    popOnly(2'b10);
    checkOutput("empty_pop_ready", 32'(pop_ready), 32'd0);

    // Asynchronous reset without a clock edge
    popOnly(2'b01);
    rst_n = 1'b0;
    #1;
    checkOutput("async_rst_count", 32'(free_count), 32'd96);
    checkOutput("async_rst_head", 32'(pop_data[0]), 32'd32);
    doReset();

    // Checkpoint take, restore discarding same-cycle pop and take
    applyStimulus(2'b11, 2'b00, 7'd0, 7'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    checkOutput("take_ckpt_head", 32'(ckpt_head), 32'd1);
    checkOutput("take_count", 32'(free_count), 32'd94);
    popOnly(2'b11);
    tick();
    popOnly(2'b11);
    tick();
    checkOutput("pre_restore_count", 32'(free_count), 32'd90);
    applyStimulus(2'b11, 2'b00, 7'd0, 7'd0, 1'b1, 2'b01, 1'b1, 2'd0);
    tick();
    checkOutput("restore_count", 32'(free_count), 32'd95);
    checkOutput("restore_ckpt_head", 32'(ckpt_head), 32'd1);
    popOnly(2'b01);
    checkOutput("restore_tag", 32'(pop_data[0]), 32'd33);
    tick();
    checkOutput("post_restore_count", 32'(free_count), 32'd94);

    // Fill remaining slots, wrap ckpt_head, restore from several slots
    applyStimulus(2'b01, 2'b00, 7'd0, 7'd0, 1'b1, 2'b01, 1'b0, 2'd0);
    tick();
    applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b1, 2'b01, 1'b0, 2'd0);
    tick();
    checkOutput("take_ckpt_head3", 32'(ckpt_head), 32'd3);
    applyStimulus(2'b11, 2'b00, 7'd0, 7'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    checkOutput("ckpt_head_wrap", 32'(ckpt_head), 32'd0);
    checkOutput("wrap_count", 32'(free_count), 32'd91);
    applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 2'b00, 1'b1, 2'd2);
    tick();
    checkOutput("restore2_count", 32'(free_count), 32'd93);
    checkOutput("restore2_ckpt_head", 32'(ckpt_head), 32'd3);
    popOnly(2'b01);
    checkOutput("restore2_tag", 32'(pop_data[0]), 32'd35);
    applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 2'b00, 1'b1, 2'd3);
    tick();
    checkOutput("restore3_count", 32'(free_count), 32'd92);
    checkOutput("restore3_ckpt_head", 32'(ckpt_head), 32'd0);
    popOnly(2'b01);
    checkOutput("restore3_tag", 32'(pop_data[0]), 32'd36);
    applyStimulus(2'b00, 2'b00, 7'd0, 7'd0, 1'b0, 2'b00, 1'b1, 2'd1);
    tick();
    checkOutput("restore1_count", 32'(free_count), 32'd94);
    checkOutput("restore1_ckpt_head", 32'(ckpt_head), 32'd2);
    popOnly(2'b01);
    checkOutput("restore1_tag", 32'(pop_data[0]), 32'd34);

    // Restore together with a 2-wide push; pushed tags come out in order
    doReset();
    popOnly(2'b11);
    tick();
    popOnly(2'b11);
    tick();
    applyStimulus(2'b11, 2'b00, 7'd0, 7'd0, 1'b1, 2'b10, 1'b0, 2'd0);
    tick();
    popOnly(2'b11);
    tick();
    applyStimulus(2'b00, 2'b11, 7'd5, 7'd7, 1'b0, 2'b00, 1'b1, 2'd0);
    tick();
    checkOutput("restore_push_count", 32'(free_count), 32'd93);
    popOnly(2'b01);
    checkOutput("restore_push_head", 32'(pop_data[0]), 32'd37);
    tick();
    for (int n = 0; n < 45; n++) begin
      popOnly(2'b11);
      tick();
    end
    checkOutput("pushed_count", 32'(free_count), 32'd2);
    popOnly(2'b11);
    checkOutput("pushed_tag5", 32'(pop_data[0]), 32'd5);
    checkOutput("pushed_tag7", 32'(pop_data[1]), 32'd7);
    tick();
    checkOutput("pushed_drained", 32'(free_count), 32'd0);

    // Sustained recycle across many buffer wraps against a FIFO model
    doReset();
    q.delete();
    for (int t = 32; t < 128; t++) q.push_back(7'(t));
    for (int n = 0; n < 300; n++) begin
      e0 = q.pop_front();
      e1 = q.pop_front();
      applyStimulus(2'b11, 2'b11, e1, e0, 1'b0, 2'b00, 1'b0, 2'd0);
      checkOutput("stream_ready", 32'(pop_ready), 32'd1);
      checkOutput("stream_lane0", 32'(pop_data[0]), 32'(e0));
      checkOutput("stream_lane1", 32'(pop_data[1]), 32'(e1));
      tick();
      q.push_back(e1);
      q.push_back(e0);
      checkOutput("stream_count", 32'(free_count), 32'd96);
    end
    popOnly(2'b00);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
